// File: rtl/dmem_arb_pkg.sv
// ---------------------------------------------------------------------------
// dmem_arb_pkg
// Shared definitions for the two-master data-memory arbiter:
//   state_e            - arbiter FSM states
//   M0 / M1            - master index / round-robin pointer values
//   RD_LAT_MIN / _MAX  - supported slave read latency range (cycles)
// ---------------------------------------------------------------------------
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } state_e;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 3;

endpackage

// File: rtl/rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-way combinational round-robin picker. A lone requester always wins;
// on a tie the master named by i_prio wins. The pointer itself is owned and
// advanced by the parent.
//   i_req  [1:0]  request vector, bit 0 = m0, bit 1 = m1
//   i_prio        tie-break winner (M0 or M1)
//   o_gnt  [1:0]  one-hot grant, all-zero when nobody requests
// ---------------------------------------------------------------------------
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_prio,
  output logic [1:0] o_gnt
);

  always_comb begin
    o_gnt = i_req;
    if (&i_req) begin
      o_gnt = (i_prio == M1) ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
// Shares one data-memory slave port between the CPU data port (m0) and a
// second bus master (m1). Each transaction runs IDLE -> ISSUE -> WAIT -> ACK:
// a single-cycle slave enable, RD_LAT cycles of wait, read-data capture on
// the last wait cycle, then a one-cycle acknowledge to the owner.
//   clk, rst                  clock, synchronous active-high reset
//   mX_req/addr/d/we          master request, byte address, write data,
//                             byte enables (all-zero = read)
//   mX_q, mX_ack              per-master read-data register, done pulse
//   s_en/addr/d/we, s_q       slave port
//   gnt                       one-hot owner while busy, 0 in IDLE
//   busy                      high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                m0_req,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_d,
  input  logic [DATA_W/8-1:0] m0_we,
  output logic [DATA_W-1:0]   m0_q,
  output logic                m0_ack,
  input  logic                m1_req,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_d,
  input  logic [DATA_W/8-1:0] m1_we,
  output logic [DATA_W-1:0]   m1_q,
  output logic                m1_ack,
  output logic                s_en,
  output logic [ADDR_W-1:0]   s_addr,
  output logic [DATA_W-1:0]   s_d,
  output logic [DATA_W/8-1:0] s_we,
  input  logic [DATA_W-1:0]   s_q,
  output logic [1:0]          gnt,
  output logic                busy
);

  localparam int BE_W = DATA_W / 8;

  // Out-of-range latencies are clamped so the 2-bit counter never wraps.
  localparam int LP_RD_LAT = (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN :
                             (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;
  localparam logic [1:0] LP_CNT_INIT = 2'(LP_RD_LAT);

  state_e            r_state;
  state_e            w_next_state;
  logic              r_owner;
  logic              r_prio;
  logic [1:0]        r_cnt;
  logic [DATA_W-1:0] r_m0_q;
  logic [DATA_W-1:0] r_m1_q;

  logic [1:0]        w_req;
  logic [1:0]        w_pick;
  logic [ADDR_W-1:0] w_own_addr;
  logic [DATA_W-1:0] w_own_d;
  logic [BE_W-1:0]   w_own_we;
  logic              w_start;
  logic              w_capture;

  assign w_req = {m1_req, m0_req};

  rr_arb2 u_rr_arb2 (
    .i_req  (w_req),
    .i_prio (r_prio),
    .o_gnt  (w_pick)
  );

  // Slave-side mux follows the latched owner, so a requester dropping or
  // changing req mid-transaction cannot redirect the slave port.
  assign w_own_addr = (r_owner == M1) ? m1_addr : m0_addr;
  assign w_own_d    = (r_owner == M1) ? m1_d    : m0_d;
  assign w_own_we   = (r_owner == M1) ? m1_we   : m0_we;

  assign w_start   = (r_state == IDLE) && (|w_req);
  assign w_capture = (r_state == WAIT) && (r_cnt == 2'd1) && (w_own_we == '0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // updates from pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: every signal driven here gets a default before the case, so no
  // path through the block leaves one unassigned and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    s_en         = 1'b0;
    s_we         = '0;
    m0_ack       = 1'b0;
    m1_ack       = 1'b0;
    gnt          = 2'b00;
    case (r_state)
      IDLE: begin
        if (|w_req) w_next_state = ISSUE;
      end
      ISSUE: begin
        gnt[r_owner] = 1'b1;
        s_en         = 1'b1;
        s_we         = w_own_we;
        w_next_state = WAIT;
      end
      WAIT: begin
        gnt[r_owner] = 1'b1;
        if (r_cnt == 2'd1) w_next_state = ACK;
      end
      ACK: begin
        gnt[r_owner] = 1'b1;
        if (r_owner == M1) m1_ack = 1'b1;
        else               m0_ack = 1'b1;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner <= M0;
      r_prio  <= M0;
      r_cnt   <= 2'd0;
      r_m0_q  <= '0;
      r_m1_q  <= '0;
    end else begin
      if (w_start) begin
        r_owner <= w_pick[1];
        // Pointer moves to whichever master did not win this grant.
        r_prio  <= w_pick[0];
      end
      if (r_state == ISSUE) begin
        r_cnt <= LP_CNT_INIT;
      end else if (r_state == WAIT) begin
        r_cnt <= r_cnt - 2'd1;
      end
      if (w_capture) begin
        if (r_owner == M1) r_m1_q <= s_q;
        else               r_m0_q <= s_q;
      end
    end
  end

  assign m0_q   = r_m0_q;
  assign m1_q   = r_m1_q;
  assign s_addr = w_own_addr;
  assign s_d    = w_own_d;
  assign busy   = (r_state != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
// Directed bench for dmem_arbiter. One instance runs with RD_LAT=1 behind a
// one-cycle registered slave model; a second runs with RD_LAT=3 behind a
// slave whose s_q is only correct exactly three cycles after s_en.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        m0_req = 1'b0, m1_req = 1'b0;
  logic [31:0] m0_addr = '0, m1_addr = '0;
  logic [31:0] m0_d = '0, m1_d = '0;
  logic [3:0]  m0_we = '0, m1_we = '0;
  logic [31:0] m0_q, m1_q;
  logic        m0_ack, m1_ack;
  logic        s_en;
  logic [31:0] s_addr, s_d;
  logic [3:0]  s_we;
  logic [31:0] s_q = '0;
  logic [1:0]  gnt;
  logic        busy;

  logic        d3_m0_req = 1'b0;
  logic [31:0] d3_m0_addr = '0;
  logic [31:0] d3_m0_d = '0;
  logic [3:0]  d3_m0_we = '0;
  logic        d3_m1_req = 1'b0;
  logic [31:0] d3_m1_addr = '0;
  logic [31:0] d3_m1_d = '0;
  logic [3:0]  d3_m1_we = '0;
  logic [31:0] d3_m0_q, d3_m1_q;
  logic        d3_m0_ack, d3_m1_ack;
  logic        d3_s_en;
  logic [31:0] d3_s_addr, d3_s_d;
  logic [3:0]  d3_s_we;
  logic [31:0] d3_s_q;
  logic [1:0]  d3_gnt;
  logic        d3_busy;
  logic [2:0]  d3_en_d = '0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_d(m0_d), .m0_we(m0_we),
    .m0_q(m0_q), .m0_ack(m0_ack),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_d(m1_d), .m1_we(m1_we),
    .m1_q(m1_q), .m1_ack(m1_ack),
    .s_en(s_en), .s_addr(s_addr), .s_d(s_d), .s_we(s_we), .s_q(s_q),
    .gnt(gnt), .busy(busy)
  );

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(3)) dut3 (
    .clk(clk), .rst(rst),
    .m0_req(d3_m0_req), .m0_addr(d3_m0_addr), .m0_d(d3_m0_d), .m0_we(d3_m0_we),
    .m0_q(d3_m0_q), .m0_ack(d3_m0_ack),
    .m1_req(d3_m1_req), .m1_addr(d3_m1_addr), .m1_d(d3_m1_d), .m1_we(d3_m1_we),
    .m1_q(d3_m1_q), .m1_ack(d3_m1_ack),
    .s_en(d3_s_en), .s_addr(d3_s_addr), .s_d(d3_s_d), .s_we(d3_s_we), .s_q(d3_s_q),
    .gnt(d3_gnt), .busy(d3_busy)
  );

  // Slave contents as seen by the bench.
  function automatic logic [31:0] slv_data(input logic [31:0] a);
    if (a == 32'h0080_0010) return 32'hDEAD_BEEF;
    return a ^ 32'h5A5A_5A5A;
  endfunction

  // One-cycle slave: data valid the cycle after s_en.
  always @(posedge clk) if (s_en) s_q <= slv_data(s_addr);

  // Three-cycle slave: garbage until exactly three cycles after s_en.
  always @(posedge clk) d3_en_d <= {d3_en_d[1:0], d3_s_en};
  assign d3_s_q = d3_en_d[2] ? 32'hCAFE_F00D :
                  d3_en_d[1] ? 32'h1111_1111 : 32'hBADB_AD00;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m0_req = 1'b0; m1_req = 1'b0; m0_we = '0; m1_we = '0;
    d3_m0_req = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (gnt !== 2'b00)  begin n_fail++; $display("FAIL reset_gnt: got %b want 00", gnt); end
    n_checks++; if (s_en !== 1'b0)  begin n_fail++; $display("FAIL reset_s_en: got %b want 0", s_en); end
    n_checks++; if (s_we !== 4'h0)  begin n_fail++; $display("FAIL reset_s_we: got %h want 0", s_we); end
    n_checks++; if ({m1_ack, m0_ack} !== 2'b00) begin n_fail++; $display("FAIL reset_acks: got %b want 00", {m1_ack, m0_ack}); end
    n_checks++; if (m0_q !== 32'h0) begin n_fail++; $display("FAIL reset_m0_q: got %h want 0", m0_q); end
    n_checks++; if (m1_q !== 32'h0) begin n_fail++; $display("FAIL reset_m1_q: got %h want 0", m1_q); end
  endtask

  task automatic test_single_read();
    m0_addr = 32'h0080_0010; m0_we = 4'h0; m0_req = 1'b1;
    n_checks++; if (s_en !== 1'b0) begin n_fail++; $display("FAIL rd_T_s_en: got %b want 0", s_en); end
    tick();  // T+1
    n_checks++; if (s_en !== 1'b1) begin n_fail++; $display("FAIL rd_issue_s_en: got %b want 1", s_en); end
    n_checks++; if (s_addr !== 32'h0080_0010) begin n_fail++; $display("FAIL rd_issue_addr: got %h want 00800010", s_addr); end
    n_checks++; if (s_we !== 4'h0) begin n_fail++; $display("FAIL rd_issue_we: got %h want 0", s_we); end
    n_checks++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL rd_issue_gnt: got %b want 01", gnt); end
    tick();  // T+2
    n_checks++; if ({s_en, m0_ack} !== 2'b00) begin n_fail++; $display("FAIL rd_wait: got s_en,ack=%b want 00", {s_en, m0_ack}); end
    tick();  // T+3
    n_checks++; if (m0_ack !== 1'b1) begin n_fail++; $display("FAIL rd_ack: got %b want 1", m0_ack); end
    n_checks++; if (m0_q !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rd_data: got %h want deadbeef", m0_q); end
    m0_req = 1'b0;
    tick();  // T+4
    n_checks++; if ({busy, m0_ack} !== 2'b00) begin n_fail++; $display("FAIL rd_idle: got busy,ack=%b want 00", {busy, m0_ack}); end
  endtask

  task automatic test_both_after_reset();
    logic [1:0] exp_ack;
    do_reset();
    m0_addr = 32'h0000_0100; m1_addr = 32'h0000_0200;
    m0_req = 1'b1; m1_req = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      exp_ack = (c == 3) ? 2'b01 : (c == 7) ? 2'b10 : 2'b00;
      n_checks++; if ({m1_ack, m0_ack} !== exp_ack) begin n_fail++; $display("FAIL both_ack c=%0d: got %b want %b", c, {m1_ack, m0_ack}, exp_ack); end
      if (c == 3) m0_req = 1'b0;
      if (c == 5) begin
        n_checks++; if ({s_en, gnt} !== 3'b110) begin n_fail++; $display("FAIL both_m1_issue: got s_en,gnt=%b want 110", {s_en, gnt}); end
        n_checks++; if (s_addr !== 32'h0000_0200) begin n_fail++; $display("FAIL both_m1_addr: got %h want 00000200", s_addr); end
      end
      if (c == 7) begin
        n_checks++; if (m1_q !== slv_data(32'h0000_0200)) begin n_fail++; $display("FAIL both_m1_q: got %h want %h", m1_q, slv_data(32'h0000_0200)); end
        m1_req = 1'b0;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_ack;
    logic [1:0] exp_gnt;
    do_reset();
    m0_addr = 32'h0000_1000; m1_addr = 32'h0000_2000;
    m0_req = 1'b1; m1_req = 1'b1;
    for (int c = 1; c <= 24; c++) begin
      tick();
      exp_gnt = ((c / 4) % 2 == 0) ? 2'b01 : 2'b10;
      exp_ack = (c % 4 == 3) ? exp_gnt : 2'b00;
      n_checks++; if ({m1_ack, m0_ack} !== exp_ack) begin n_fail++; $display("FAIL b2b_ack c=%0d: got %b want %b", c, {m1_ack, m0_ack}, exp_ack); end
      if (c % 4 == 1) begin
        n_checks++; if (gnt !== exp_gnt) begin n_fail++; $display("FAIL b2b_gnt c=%0d: got %b want %b", c, gnt, exp_gnt); end
      end
      if (c == 23) begin m0_req = 1'b0; m1_req = 1'b0; end
    end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_end_busy: got %b want 0", busy); end
  endtask

  task automatic test_write();
    do_reset();
    m1_addr = 32'h0000_0040; m1_we = 4'h0; m1_req = 1'b1;
    tick(); tick(); tick();
    n_checks++; if (m1_q !== slv_data(32'h0000_0040)) begin n_fail++; $display("FAIL wr_pre_read_q: got %h want %h", m1_q, slv_data(32'h0000_0040)); end
    m1_req = 1'b0;
    tick();
    m1_addr = 32'h0000_0044; m1_d = 32'h1234_5678; m1_we = 4'b0011; m1_req = 1'b1;
    tick();  // ISSUE
    n_checks++; if ({s_en, gnt} !== 3'b110) begin n_fail++; $display("FAIL wr_issue_en_gnt: got %b want 110", {s_en, gnt}); end
    n_checks++; if (s_we !== 4'b0011) begin n_fail++; $display("FAIL wr_issue_we: got %b want 0011", s_we); end
    n_checks++; if (s_d !== 32'h1234_5678) begin n_fail++; $display("FAIL wr_issue_d: got %h want 12345678", s_d); end
    tick();  // WAIT
    n_checks++; if (s_we !== 4'h0) begin n_fail++; $display("FAIL wr_wait_we: got %b want 0000", s_we); end
    tick();  // ACK
    n_checks++; if (m1_ack !== 1'b1) begin n_fail++; $display("FAIL wr_ack: got %b want 1", m1_ack); end
    n_checks++; if (m1_q !== slv_data(32'h0000_0040)) begin n_fail++; $display("FAIL wr_q_kept: got %h want %h", m1_q, slv_data(32'h0000_0040)); end
    m1_req = 1'b0; m1_we = 4'h0;
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    m0_addr = 32'h0000_0080; m0_req = 1'b1;
    tick(); tick(); tick();
    n_checks++; if (m0_q !== slv_data(32'h0000_0080)) begin n_fail++; $display("FAIL rst_pre_q: got %h want %h", m0_q, slv_data(32'h0000_0080)); end
    m0_req = 1'b0;
    tick();
    m0_addr = 32'h0000_0084; m0_req = 1'b1;  // T
    tick();                                  // T+1 ISSUE
    tick();                                  // T+2 WAIT
    rst = 1'b1;
    tick();                                  // T+3 after reset
    n_checks++; if ({busy, s_en, m1_ack, m0_ack} !== 4'b0000) begin n_fail++; $display("FAIL rst_mid_ctrl: got busy,s_en,acks=%b want 0000", {busy, s_en, m1_ack, m0_ack}); end
    n_checks++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL rst_mid_gnt: got %b want 00", gnt); end
    n_checks++; if ({m0_q, m1_q} !== 64'h0) begin n_fail++; $display("FAIL rst_mid_q: got %h %h want 0 0", m0_q, m1_q); end
    rst = 1'b0;
    m1_addr = 32'h0000_0090; m1_req = 1'b1;
    tick();                                  // T+4
    n_checks++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL rst_first_gnt: got %b want 01", gnt); end
    tick();
    tick();                                  // T+6 ACK
    n_checks++; if ({m1_ack, m0_ack} !== 2'b01) begin n_fail++; $display("FAIL rst_after_ack: got %b want 01", {m1_ack, m0_ack}); end
    m0_req = 1'b0; m1_req = 1'b0;
    tick();
  endtask

  task automatic test_rd_lat3();
    do_reset();
    d3_m0_addr = 32'h0000_0300; d3_m0_req = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 1) begin
        n_checks++; if (d3_s_en !== 1'b1) begin n_fail++; $display("FAIL lat3_issue: got %b want 1", d3_s_en); end
      end
      n_checks++; if (d3_m0_ack !== (c == 5)) begin n_fail++; $display("FAIL lat3_ack c=%0d: got %b want %b", c, d3_m0_ack, (c == 5)); end
      if (c == 5) begin
        n_checks++; if (d3_m0_q !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL lat3_data: got %h want cafef00d", d3_m0_q); end
        d3_m0_req = 1'b0;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_read();
    test_both_after_reset();
    test_back_to_back();
    test_write();
    test_reset_mid();
    test_rd_lat3();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
